// File: rtl/bsg_dff_en_unloader.sv
// Two-entry in-order buffer that captures enable-strobed register writes and
// presents them on a valid/yumi port; writes that find no room are dropped and counted.
//
// state | meaning
// ------+-----------------------------------------------
// EMPTY | no words buffered, v_o low
// ONE   | one word buffered at rd_ptr
// FULL  | both entries occupied; a write needs a same-cycle yumi
module bsg_dff_en_unloader #(
   parameter int width_p          = 8,
   parameter int drop_ctr_width_p = 8,
   parameter bit assert_en_p      = 1'b1
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        en_i,
   input  logic [width_p-1:0]          data_i,
   output logic                        v_o,
   output logic [width_p-1:0]          data_o,
   input  logic                        yumi_i,
   output logic                        full_o,
   output logic                        overflow_o,
   output logic [drop_ctr_width_p-1:0] drop_count_o
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_e;

   occ_e                        occ;
   logic [width_p-1:0]          mem [2];
   logic                        rd_ptr;
   logic                        wr_ptr;
   logic                        overflow;
   logic [drop_ctr_width_p-1:0] drop_count;

   logic deq;
   logic acc;
   logic drop;

   // When FULL, an accepted write relies on the same-cycle dequeue freeing a slot.
   assign deq  = yumi_i && (occ != EMPTY);
   assign acc  = en_i && ((occ != FULL) || yumi_i);
   assign drop = en_i && !acc;

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         occ        <= EMPTY;
         mem[0]     <= '0;
         mem[1]     <= '0;
         rd_ptr     <= 1'b0;
         wr_ptr     <= 1'b0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         if (acc) begin
            mem[wr_ptr] <= data_i;
            wr_ptr      <= ~wr_ptr;
         end
         if (deq)
            rd_ptr <= ~rd_ptr;
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1)
               drop_count <= drop_count + 1'b1;
         end
         unique case (occ)
            EMPTY:   occ <= acc ? ONE : EMPTY;
            ONE: begin
               if (acc && !deq)      occ <= FULL;
               else if (!acc && deq) occ <= EMPTY;
               else                  occ <= ONE;
            end
            FULL:    occ <= (deq && !acc) ? ONE : FULL;
            default: occ <= EMPTY;
         endcase
      end
   end

   assign v_o          = (occ != EMPTY);
   assign full_o       = (occ == FULL);
   assign data_o       = mem[rd_ptr];
   assign overflow_o   = overflow;
   assign drop_count_o = drop_count;

   // Consumer must not take a word that is not there; state is left untouched if it does.
   assert property (@(posedge clk_i) disable iff (!reset_n_i || !assert_en_p)
                    !(yumi_i && !v_o))
      else $error("bsg_dff_en_unloader: yumi_i asserted while v_o is low");

endmodule

// File: tb/tb_bsg_dff_en_unloader.sv
// Directed bench for bsg_dff_en_unloader: a queue model checked every cycle,
// plus literal expectations along the scripted sequence.
module tb_bsg_dff_en_unloader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // instance A: default widths, assertion live
   logic       a_rst_n = 1'b0, a_en = 1'b0, a_yumi = 1'b0;
   logic [7:0] a_din = '0;
   logic       a_v, a_full, a_ovf;
   logic [7:0] a_dout, a_dc;

   // instance B: 2-bit drop counter, assertion disabled so the illegal-yumi case can run
   logic       b_rst_n = 1'b0, b_en = 1'b0, b_yumi = 1'b0;
   logic [7:0] b_din = '0;
   logic       b_v, b_full, b_ovf;
   logic [7:0] b_dout;
   logic [1:0] b_dc;

   bsg_dff_en_unloader #(.width_p(8), .drop_ctr_width_p(8), .assert_en_p(1'b1)) dut_a (
      .clk_i(clk), .reset_n_i(a_rst_n), .en_i(a_en), .data_i(a_din),
      .v_o(a_v), .data_o(a_dout), .yumi_i(a_yumi), .full_o(a_full),
      .overflow_o(a_ovf), .drop_count_o(a_dc));

   bsg_dff_en_unloader #(.width_p(8), .drop_ctr_width_p(2), .assert_en_p(1'b0)) dut_b (
      .clk_i(clk), .reset_n_i(b_rst_n), .en_i(b_en), .data_i(b_din),
      .v_o(b_v), .data_o(b_dout), .yumi_i(b_yumi), .full_o(b_full),
      .overflow_o(b_ovf), .drop_count_o(b_dc));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a bounded queue of depth 2 plus drop bookkeeping.
   logic [7:0] qa[$], qb[$];
   bit         ovfa, ovfb;
   int         dca, dcb;
   bit         armed = 1'b0;

   always @(posedge clk) begin
      armed = 1'b1;
      if (!a_rst_n) begin
         qa.delete(); ovfa = 0; dca = 0;
      end else begin
         bit room;
         room = (qa.size() < 2) || a_yumi;
         if (a_yumi && qa.size() > 0) void'(qa.pop_front());
         if (a_en) begin
            if (room) qa.push_back(a_din);
            else begin ovfa = 1; if (dca < 255) dca++; end
         end
      end
      if (!b_rst_n) begin
         qb.delete(); ovfb = 0; dcb = 0;
      end else begin
         bit room;
         room = (qb.size() < 2) || (b_yumi && qb.size() > 0);
         if (b_yumi && qb.size() > 0) void'(qb.pop_front());
         if (b_en) begin
            if (room) qb.push_back(b_din);
            else begin ovfb = 1; if (dcb < 3) dcb++; end
         end
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("a_v",    a_v,    qa.size() != 0);
         chk("a_full", a_full, qa.size() == 2);
         chk("a_ovf",  a_ovf,  ovfa);
         chk("a_dc",   a_dc,   dca);
         if (qa.size() > 0) chk("a_data", a_dout, qa[0]);
         chk("b_v",    b_v,    qb.size() != 0);
         chk("b_full", b_full, qb.size() == 2);
         chk("b_ovf",  b_ovf,  ovfb);
         chk("b_dc",   b_dc,   dcb);
         if (qb.size() > 0) chk("b_data", b_dout, qb[0]);
      end
   end

   task automatic a_step(input logic rst_n, input logic en, input logic [7:0] d, input logic y);
      a_rst_n = rst_n; a_en = en; a_din = d; a_yumi = y;
      @(posedge clk); #1;
   endtask

   task automatic b_step(input logic rst_n, input logic en, input logic [7:0] d, input logic y);
      b_rst_n = rst_n; b_en = en; b_din = d; b_yumi = y;
      @(posedge clk); #1;
   endtask

   initial begin
      // reset held two cycles
      a_step(0, 0, 8'h00, 0);
      a_step(0, 0, 8'h00, 0);
      chk("rst_v",    a_v,    1'b0);
      chk("rst_full", a_full, 1'b0);
      chk("rst_ovf",  a_ovf,  1'b0);
      chk("rst_dc",   a_dc,   8'h00);
      chk("rst_data", a_dout, 8'h00);

      // single word
      a_step(1, 1, 8'h01, 0);
      chk("single_v",    a_v,    1'b1);
      chk("single_data", a_dout, 8'h01);
      chk("single_full", a_full, 1'b0);
      a_step(1, 0, 8'h00, 1);
      chk("single_drained", a_v, 1'b0);

      // thermometer burst without yumi: third word dropped
      a_step(1, 1, 8'h01, 0);
      a_step(1, 1, 8'h03, 0);
      a_step(1, 1, 8'h07, 0);
      chk("therm_full", a_full, 1'b1);
      chk("therm_ovf",  a_ovf,  1'b1);
      chk("therm_dc",   a_dc,   8'h01);
      chk("therm_head0", a_dout, 8'h01);
      a_step(1, 0, 8'h00, 1);
      chk("therm_head1", a_dout, 8'h03);
      a_step(1, 0, 8'h00, 1);
      chk("therm_empty", a_v, 1'b0);
      chk("therm_sticky", a_ovf, 1'b1);

      // full with simultaneous write and yumi: no drop
      a_step(1, 1, 8'h01, 0);
      a_step(1, 1, 8'h03, 0);
      a_step(1, 1, 8'h07, 1);
      chk("simul_dc",   a_dc,   8'h01);
      chk("simul_full", a_full, 1'b1);
      chk("simul_head", a_dout, 8'h03);
      a_step(1, 0, 8'h00, 1);
      chk("simul_head2", a_dout, 8'h07);
      a_step(1, 0, 8'h00, 1);
      chk("simul_empty", a_v, 1'b0);

      // reset mid-operation with a write offered on the reset edge
      a_step(1, 1, 8'h01, 0);
      a_step(1, 1, 8'h03, 0);
      a_step(1, 1, 8'h07, 0);
      chk("midrst_dc_before", a_dc, 8'h02);
      a_step(0, 1, 8'h0F, 0);
      chk("midrst_v",    a_v,    1'b0);
      chk("midrst_full", a_full, 1'b0);
      chk("midrst_ovf",  a_ovf,  1'b0);
      chk("midrst_dc",   a_dc,   8'h00);
      chk("midrst_data", a_dout, 8'h00);
      a_step(1, 0, 8'h00, 0);
      chk("midrst_not_stored", a_v, 1'b0);

      // sustained one-in/one-out streaming
      for (int i = 0; i < 10; i++)
         a_step(1, 1, 8'(8'h20 + i), qa.size() > 0);
      chk("stream_dc", a_dc, 8'h00);
      a_step(1, 0, 8'h00, 1);
      a_step(1, 0, 8'h00, 0);

      // saturation on the 2-bit counter
      b_step(0, 0, 8'h00, 0);
      b_step(0, 0, 8'h00, 0);
      b_step(1, 1, 8'hA1, 0);
      b_step(1, 1, 8'hA2, 0);
      for (int i = 0; i < 5; i++) b_step(1, 1, 8'(8'hB0 + i), 0);
      chk("sat_dc", b_dc, 2'd3);
      b_step(1, 1, 8'hC0, 0);
      chk("sat_hold", b_dc, 2'd3);
      chk("sat_head", b_dout, 8'hA1);

      // illegal yumi on empty, then a normal write
      b_step(0, 0, 8'h00, 0);
      b_step(1, 0, 8'h00, 1);
      chk("illegal_v",    b_v,    1'b0);
      chk("illegal_full", b_full, 1'b0);
      b_step(1, 1, 8'h05, 0);
      chk("after_illegal_v",    b_v,    1'b1);
      chk("after_illegal_data", b_dout, 8'h05);
      b_step(1, 0, 8'h00, 1);
      chk("after_illegal_empty", b_v, 1'b0);
      b_step(1, 0, 8'h00, 0);

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bsg_dff_en_unloader.md
# bsg_dff_en_unloader

Read-side companion to an enable-strobed register write port. It captures each `en_i`-qualified write of `data_i` into a 2-entry in-order buffer and presents the words on a valid/yumi consumer interface. The writer has no backpressure, so writes that find the buffer full are dropped and reported through a sticky overflow flag and a saturating drop counter. The block sits between a free-running producer of register updates and a consumer that may stall.

## Interface
- `width_p`, default 8: data word width in bits (≥1).
- `drop_ctr_width_p`, default 8: width of the drop counter (≥1).

- `clk_i`  in  1  sole clock; all state updates on posedge.
- `reset_n_i`  in  1  synchronous, active-low reset, sampled on posedge.
- `en_i`  in  1  write strobe; `data_i` is offered this cycle.
- `data_i`  in  `width_p`  write data.
- `v_o`  out  1  head entry valid.
- `data_o`  out  `width_p`  head entry data.
- `yumi_i`  in  1  consumer takes the head entry this cycle; legal only when `v_o`=1.
- `full_o`  out  1  both entries occupied.
- `overflow_o`  out  1  sticky: at least one write dropped since reset.
- `drop_count_o`  out  `drop_ctr_width_p`  number of dropped writes, saturating at all-ones.

## Operation
- Storage: two `width_p` entries, read pointer, write pointer, occupancy count 0..2. Strict FIFO order.
- Occupancy states:
  - EMPTY (count 0).
  - ONE (count 1).
  - FULL (count 2).
- A write is accepted when `en_i`=1 and either count<2, or count=2 and `yumi_i`=1 in the same cycle (the dequeue frees a slot).
- A write with `en_i`=1 that is not accepted is dropped:
  - `overflow_o` is set and stays set until reset.
  - `drop_count_o` increments by 1 unless it is all-ones.
- Dequeue occurs when `yumi_i`=1 and count>0; the read pointer advances.
- `yumi_i`=1 with count=0 is a protocol violation. The state is unchanged and the simulation-only assertion fires.
- Simultaneous accept and dequeue leaves the count unchanged; both pointers advance.
- Pointers wrap modulo 2.
- `v_o` = (count≠0). `data_o` = entry at the read pointer, undefined-free: it shows the stored value even when `v_o`=0.
- `full_o` = (count=2).
- Reset (`reset_n_i`=0 at a posedge):
  - count, pointers, `overflow_o` and `drop_count_o` go to 0.
  - Both entries go to 0, so `data_o`=0.
  - `en_i` and `yumi_i` are ignored on reset cycles.
  - Reset mid-operation discards all buffered words.

## Timing
- Write-to-visible latency is 1 cycle. A word accepted at edge k drives `v_o`/`data_o` from just after edge k. There is no combinational bypass from `data_i` to `data_o`.
- All outputs are registered or decoded only from registers. No output depends combinationally on `en_i`, `data_i` or `yumi_i`.
- `overflow_o` and `drop_count_o` update at the same edge that drops the write.
- Output values after the first reset edge: `v_o`=0, `full_o`=0, `overflow_o`=0, `drop_count_o`=0, `data_o`=0.
- Throughput is one write and one read per cycle sustained when the consumer asserts `yumi_i` every cycle that `v_o`=1.

## Test plan
- **Single word:** hold reset 2 cycles, then `en_i`=1 with `data_i`=0x01 for one cycle. Required: next cycle `v_o`=1, `data_o`=0x01, `full_o`=0. `yumi_i`=1 for one cycle, then `v_o`=0.
- **Thermometer burst with no yumi:** write 0x01, 0x03, 0x07 on consecutive cycles. Required after the burst: `full_o`=1, `overflow_o`=1, `drop_count_o`=1. Draining yields 0x01 then 0x03, then `v_o`=0; `overflow_o` stays 1.
- **Full with simultaneous write and yumi:** buffer holds 0x01, 0x03; `en_i`=1 with `data_i`=0x07 and `yumi_i`=1 in the same cycle. Required: no drop (`drop_count_o` unchanged), `full_o`=1, drain order 0x03, 0x07.
- **Saturation:** with `drop_ctr_width_p`=2, fill the buffer, then issue 5 writes with no yumi. Required: `drop_count_o`=3 and held there.
- **Reset mid-operation:** buffer full and `overflow_o`=1; drive `reset_n_i`=0 for one edge while `en_i`=1 with `data_i`=0x0F. Required: next cycle all outputs are 0 and the word is not stored.
- **Illegal yumi:** `yumi_i`=1 while `v_o`=0. Required: count stays 0, `v_o` stays 0, the assertion reports an error; a following write of 0x05 is delivered normally.
